// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 lane decoder.
// Scan-code prefixes, arrow codes, default lane/start codes and the settle FSM states.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Extended (E0-prefixed) arrow codes, mapped onto lanes 0..3
    localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
    localparam logic [7:0] SC_ARROW_UP    = 8'h75;
    localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;

    localparam logic [7:0] DEF_LANE0_CODE = 8'h23;  // D
    localparam logic [7:0] DEF_LANE1_CODE = 8'h2B;  // F
    localparam logic [7:0] DEF_LANE2_CODE = 8'h3B;  // J
    localparam logic [7:0] DEF_LANE3_CODE = 8'h42;  // K
    localparam logic [7:0] DEF_START_CODE = 8'h29;  // Space

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        DECODE = 2'd2
    } settle_state_t;

    // One-hot lane match of a byte against the arrow codes
    function automatic logic [3:0] arrow_hit(input logic [7:0] code);
        arrow_hit = {code == SC_ARROW_RIGHT, code == SC_ARROW_UP,
                     code == SC_ARROW_DOWN,  code == SC_ARROW_LEFT};
    endfunction

endpackage

// File: rtl/ps2_word_settle.sv
// Synchronises the receiver's byte window and waits for it to stay unchanged
// for STABLE_CYCLES clocks. Emits the settled word with a one-cycle strobe,
// suppressed when the window merely returned to the last decoded value.
//
// state  | meaning
// WAIT   | window equals last decoded word, idle
// SETTLE | candidate captured, counting stable cycles
// DECODE | candidate accepted, strobe high for this cycle
module ps2_word_settle #(
    parameter int STABLE_CYCLES = 3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] key_word,
    output logic [15:0] cand,
    output logic        settled
);
    import ps2_pkg::*;

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [15:0]   kw_s1, kw_s2;
    logic [15:0]   last_word;
    logic [CW-1:0] cnt;
    settle_state_t state;

    // Two-flop synchroniser; per-bit skew is absorbed by the settle check
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kw_s1 <= 16'h0000;
            kw_s2 <= 16'h0000;
        end else begin
            kw_s1 <= key_word;
            kw_s2 <= kw_s1;
        end
    end

    // Settle FSM with restartable stable-cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= WAIT;
            cand      <= 16'h0000;
            last_word <= 16'h0000;
            cnt       <= '0;
            settled   <= 1'b0;
        end else begin
            settled <= 1'b0;
            case (state)
                WAIT: begin
                    if (kw_s2 != last_word) begin
                        state <= SETTLE;
                        cand  <= kw_s2;
                        cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (kw_s2 != cand) begin
                        cand <= kw_s2;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= DECODE;
                        settled <= (cand != last_word);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DECODE: begin
                    last_word <= cand;
                    state     <= WAIT;
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: rtl/ps2_lane_decoder.sv
// PS/2 lane decoder: turns the settled byte window into held lane levels,
// lane press/release pulses and a start-key pulse for the whitetile game.
// Build option: define PS2_LANE_ARROW_EN to let the extended arrow keys
// drive lanes 0..3 alongside the letter keys.
module ps2_lane_decoder #(
    parameter int         STABLE_CYCLES = 3000,
    parameter logic [7:0] LANE0_CODE    = 8'h23,
    parameter logic [7:0] LANE1_CODE    = 8'h2B,
    parameter logic [7:0] LANE2_CODE    = 8'h3B,
    parameter logic [7:0] LANE3_CODE    = 8'h42,
    parameter logic [7:0] START_CODE    = 8'h29
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] key_word,
    output logic [3:0]  lane_down,
    output logic [3:0]  lane_press,
    output logic [3:0]  lane_release,
    output logic        start_press,
    output logic [7:0]  last_code
);
    import ps2_pkg::*;

    logic [15:0] cand;
    logic        settled;
    logic [7:0]  newb, prevb;
    logic        brk;
    logic        ext_pend;
    logic [3:0]  letter_down, letter_hit, letter_next;
    logic [3:0]  arrow_next;
    logic [3:0]  lane_next;

    ps2_word_settle #(.STABLE_CYCLES(STABLE_CYCLES)) u_settle (
        .clk      (clk),
        .reset    (reset),
        .key_word (key_word),
        .cand     (cand),
        .settled  (settled)
    );

    assign newb  = cand[7:0];
    assign prevb = cand[15:8];
    assign brk   = (prevb == SC_BREAK);

    assign letter_hit = {newb == LANE3_CODE, newb == LANE2_CODE,
                         newb == LANE1_CODE, newb == LANE0_CODE};

`ifdef PS2_LANE_ARROW_EN
    logic [3:0] arrow_down;

    // Arrow-key source: only extended bytes touch it
    always_comb begin
        arrow_next = arrow_down;
        if (ext_pend)
            arrow_next = brk ? (arrow_down & ~arrow_hit(newb))
                             : (arrow_down | arrow_hit(newb));
    end

    // Arrow-key held state, updated on every decoded non-prefix byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            arrow_down <= 4'b0000;
        else if (settled && newb != SC_EXT && newb != SC_BREAK)
            arrow_down <= arrow_next;
    end
`else
    assign arrow_next = 4'b0000;
`endif

    // Letter-key source: extended bytes are never mistaken for letter codes
    always_comb begin
        letter_next = letter_down;
        if (!ext_pend)
            letter_next = brk ? (letter_down & ~letter_hit)
                              : (letter_down | letter_hit);
    end

    assign lane_next = letter_next | arrow_next;

    // Decode strobe handling; pulses come from the lane_down edge in the same register stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_pend     <= 1'b0;
            letter_down  <= 4'b0000;
            lane_down    <= 4'b0000;
            lane_press   <= 4'b0000;
            lane_release <= 4'b0000;
            start_press  <= 1'b0;
            last_code    <= 8'h00;
        end else begin
            lane_press   <= 4'b0000;
            lane_release <= 4'b0000;
            start_press  <= 1'b0;
            if (settled) begin
                if (newb == SC_EXT) begin
                    ext_pend <= 1'b1;
                end else if (newb != SC_BREAK) begin
                    ext_pend     <= 1'b0;
                    last_code    <= newb;
                    letter_down  <= letter_next;
                    lane_down    <= lane_next;
                    lane_press   <= lane_next & ~lane_down;
                    lane_release <= lane_down & ~lane_next;
                    start_press  <= !brk && !ext_pend && (newb == START_CODE);
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_lane_decoder.sv
// Directed bench for ps2_lane_decoder with a short settle window.
module tb_ps2_lane_decoder;

    localparam int SC = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] key_word = 16'h0000;
    logic [3:0]  lane_down, lane_press, lane_release;
    logic        start_press;
    logic [7:0]  last_code;

    int checks = 0;
    int failures = 0;

    logic clr = 1'b1;
    int press_cnt [4];
    int rel_cnt [4];
    int start_cnt;

    ps2_lane_decoder #(.STABLE_CYCLES(SC)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_word     (key_word),
        .lane_down    (lane_down),
        .lane_press   (lane_press),
        .lane_release (lane_release),
        .start_press  (start_press),
        .last_code    (last_code)
    );

    always #5 clk = ~clk;

    // Pulse counters, cleared while clr is high
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                press_cnt[i] <= 0;
                rel_cnt[i]   <= 0;
            end
            start_cnt <= 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                press_cnt[i] <= press_cnt[i] + int'(lane_press[i]);
                rel_cnt[i]   <= rel_cnt[i] + int'(lane_release[i]);
            end
            start_cnt <= start_cnt + int'(start_press);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clr = 1'b1;
        key_word = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        clr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic hold(input logic [15:0] w, input int n);
        @(negedge clk);
        key_word = w;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        // Reset values
        reset = 1'b0;
        #1;
        chk("rst_down", 32'(lane_down), 32'h0);
        chk("rst_last", 32'(last_code), 32'h0);
        do_reset();
        chk("pwrup_down", 32'(lane_down), 32'h0);

        // 1: lane 0 make, exact latency
        @(negedge clk);
        key_word = 16'h0023;
        repeat (SC + 3) @(posedge clk);
        #1;
        chk("t1_early_press", 32'(lane_press), 32'h0);
        chk("t1_early_down", 32'(lane_down), 32'h0);
        @(posedge clk);
        #1;
        chk("t1_press", 32'(lane_press), 32'h1);
        chk("t1_down", 32'(lane_down), 32'h1);
        chk("t1_last", 32'(last_code), 32'h23);
        @(posedge clk);
        #1;
        chk("t1_press_1cyc", 32'(lane_press), 32'h0);
        chk("t1_down_held", 32'(lane_down), 32'h1);

        // 2: break sequence releases lane 0
        clear_counts();
        hold(16'h23F0, 40);
        chk("t2_f0_no_rel", 32'(rel_cnt[0]), 32'd0);
        hold(16'hF023, 40);
        chk("t2_rel0", 32'(rel_cnt[0]), 32'd1);
        chk("t2_press0", 32'(press_cnt[0]), 32'd0);
        chk("t2_down", 32'(lane_down), 32'h0);

        // 3: fast toggling never settles, then lane 1 make
        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] r;
            r = $urandom();
            hold(r[15:0], 5);
        end
        chk("t3_quiet_press", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'd0);
        chk("t3_quiet_start", 32'(start_cnt), 32'd0);
        hold(16'h002B, 40);
        chk("t3_press1", 32'(press_cnt[1]), 32'd1);
        chk("t3_press_other", 32'(press_cnt[0] + press_cnt[2] + press_cnt[3]), 32'd0);
        chk("t3_rel", 32'(rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3]), 32'd0);
        chk("t3_down", 32'(lane_down), 32'h2);

        // 4: typematic repeat and repeated start makes
        do_reset();
        hold(16'h0023, 40);
        hold(16'h2323, 40);
        chk("t4_single_press", 32'(press_cnt[0]), 32'd1);
        chk("t4_down", 32'(lane_down), 32'h1);
        hold(16'h0029, 40);
        chk("t4_start1", 32'(start_cnt), 32'd1);
        hold(16'h2929, 40);
        chk("t4_start2", 32'(start_cnt), 32'd2);
        chk("t4_last", 32'(last_code), 32'h29);
        hold(16'h29F0, 40);
        hold(16'hF029, 40);
        chk("t4_start_brk", 32'(start_cnt), 32'd2);

        // 5: extended left arrow make then break
        do_reset();
        hold(16'h00E0, 40);
        hold(16'hE06B, 40);
`ifdef PS2_LANE_ARROW_EN
        chk("t5_arrow_press", 32'(press_cnt[0]), 32'd1);
        chk("t5_arrow_down", 32'(lane_down), 32'h1);
`else
        chk("t5_arrow_press", 32'(press_cnt[0]), 32'd0);
        chk("t5_arrow_down", 32'(lane_down), 32'h0);
`endif
        hold(16'h6BE0, 40);
        hold(16'hE0F0, 40);
        hold(16'hF06B, 40);
`ifdef PS2_LANE_ARROW_EN
        chk("t5_arrow_rel", 32'(rel_cnt[0]), 32'd1);
`else
        chk("t5_arrow_rel", 32'(rel_cnt[0]), 32'd0);
`endif
        chk("t5_down_end", 32'(lane_down), 32'h0);
        chk("t5_last", 32'(last_code), 32'h6B);

        // 6: reset in the middle of a settle
        do_reset();
        hold(16'h0023, 40);
        chk("t6_pre_down", 32'(lane_down), 32'h1);
        hold(16'h0042, 10);
        @(negedge clk);
        reset = 1'b0;
        clr = 1'b1;
        #1;
        chk("t6_rst_down", 32'(lane_down), 32'h0);
        chk("t6_rst_last", 32'(last_code), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        clr = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("t6_press3", 32'(press_cnt[3]), 32'd1);
        chk("t6_press0", 32'(press_cnt[0]), 32'd0);
        chk("t6_down", 32'(lane_down), 32'h8);
        chk("t6_last", 32'(last_code), 32'h42);
        hold(16'h0042, 40);
        chk("t6_press3_once", 32'(press_cnt[3]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
